// File: rtl/pad_mask_gen.sv
// pad_mask_gen
//
// Generates per-member full-sum masks and Center-Left-Right edge codes for
// same-size convolutions with both horizontal and vertical padding. The block
// tracks the current column/row of the output image internally and presents one
// registered output beat per accepted input beat through a valid/ready stage.
//
// Ports:
//   aclk, aresetn     clock and asynchronous active-low reset
//   aclken            clock enable; low freezes every register
//   s_valid/s_ready   input handshake (s_ready = !m_valid || m_ready)
//   s_config          beat carries a new configuration
//   s_cin_last        beat is the last channel accumulation of a pixel
//   s_kw2, s_kh2      kernel half-width / half-height (config beats)
//   s_cols_1/s_rows_1 image columns-1 / rows-1 (config beats)
//   m_valid/m_ready   output handshake
//   m_mask_full       member m carries a complete sum
//   m_clr             column code: 0 centre, odd left, even right
//   m_rcode           row code: 0 centre, odd top, even bottom
//   m_config          registered s_config
//   m_last            final pixel of the frame
//   cfg_err           sticky flag for an illegal configuration
module pad_mask_gen #(
    parameter int KW_MAX    = 7,
    parameter int KH_MAX    = 7,
    parameter int MEMBERS   = 24,
    parameter int BITS_COLS = 10,
    parameter int BITS_ROWS = 10,
    parameter int BITS_KW   = $clog2(KW_MAX + 1),
    localparam int KW2_W    = $clog2(KW_MAX / 2 + 1),
    localparam int KH2_W    = $clog2(KH_MAX / 2 + 1)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 aclken,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_config,
    input  logic                 s_cin_last,
    input  logic [KW2_W-1:0]     s_kw2,
    input  logic [KH2_W-1:0]     s_kh2,
    input  logic [BITS_COLS-1:0] s_cols_1,
    input  logic [BITS_ROWS-1:0] s_rows_1,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [MEMBERS-1:0]   m_mask_full,
    output logic [BITS_KW-1:0]   m_clr,
    output logic [BITS_KW-1:0]   m_rcode,
    output logic                 m_config,
    output logic                 m_last,
    output logic                 cfg_err
);

    localparam int KW2_N = 2 ** KW2_W;
    localparam int CW    = BITS_COLS + 2;
    localparam int RW    = BITS_ROWS + 2;

    // Members whose kernel window closes at this column: the last tap of each
    // kw-wide group.
    function automatic logic [MEMBERS-1:0] period_mask(input int k);
        logic [MEMBERS-1:0] v;
        int kw;
        kw = 2 * k + 1;
        for (int m = 0; m < MEMBERS; m++) begin
            v[m] = ((m % kw) == (kw - 1));
        end
        return v;
    endfunction

    // Extra members that complete on the last column because the right-hand
    // padding supplies their missing taps; trailing members that do not form a
    // whole group never complete.
    function automatic logic [MEMBERS-1:0] tail_mask(input int k);
        logic [MEMBERS-1:0] v;
        int kw;
        kw = 2 * k + 1;
        for (int m = 0; m < MEMBERS; m++) begin
            v[m] = ((m % kw) >= k) && (m < (MEMBERS / kw) * kw);
        end
        return v;
    endfunction

    logic [KW2_W-1:0]     kw2;
    logic [KH2_W-1:0]     kh2;
    logic [BITS_COLS-1:0] cols_1;
    logic [BITS_ROWS-1:0] rows_1;
    logic [BITS_COLS-1:0] col;
    logic [BITS_ROWS-1:0] row;

    logic [MEMBERS-1:0]   period_tab [KW2_N];
    logic [MEMBERS-1:0]   tail_tab   [KW2_N];

    logic                 fire;
    logic                 at_col_end;
    logic                 at_row_end;
    logic                 cfg_bad;
    logic                 col_left;
    logic                 col_right;
    logic                 row_top;
    logic                 row_bottom;
    logic [CW-1:0]        col_x;
    logic [CW-1:0]        cols_x;
    logic [CW-1:0]        kw2_x;
    logic [CW-1:0]        col_rem;
    logic [RW-1:0]        row_x;
    logic [RW-1:0]        rows_x;
    logic [RW-1:0]        kh2_x;
    logic [RW-1:0]        row_rem;
    logic [BITS_KW-1:0]   col_code;
    logic [BITS_KW-1:0]   row_code;
    logic [MEMBERS-1:0]   mask_next;

    // Masks depend only on kw2, so they are constant tables indexed by it.
    generate
        for (genvar k = 0; k < KW2_N; k++) begin : g_tab
            assign period_tab[k] = period_mask(k);
            assign tail_tab[k]   = tail_mask(k);
        end
    endgenerate

    assign s_ready    = !m_valid || m_ready;
    assign fire       = s_valid && s_ready && aclken;
    assign at_col_end = (col == cols_1);
    assign at_row_end = (row == rows_1);

    // Legal only if the image is at least as large as the kernel in both axes.
    // Compared as cols_1 < 2*kw2, which is cols_1+1 < 2*kw2+1 without overflow.
    assign cfg_bad = (CW'(s_cols_1) < (CW'(s_kw2) << 1)) ||
                     (RW'(s_rows_1) < (RW'(s_kh2) << 1));

    // Column edge code, evaluated in a widened domain so that configurations
    // with a kernel wider than the image cannot wrap the comparisons. The left
    // edge wins if both edges apply.
    always_comb begin
        col_x     = CW'(col);
        cols_x    = CW'(cols_1);
        kw2_x     = CW'(kw2);
        col_left  = col_x < kw2_x;
        col_right = (col_x + kw2_x) > cols_x;
        col_rem   = cols_x - col_x + CW'(1);
        col_code  = '0;
        if (col_left) begin
            col_code = BITS_KW'({col_x, 1'b1});
        end else if (col_right) begin
            col_code = BITS_KW'({col_rem, 1'b0});
        end
    end

    // Row edge code, same rule as the columns using the kernel half-height.
    always_comb begin
        row_x      = RW'(row);
        rows_x     = RW'(rows_1);
        kh2_x      = RW'(kh2);
        row_top    = row_x < kh2_x;
        row_bottom = (row_x + kh2_x) > rows_x;
        row_rem    = rows_x - row_x + RW'(1);
        row_code   = '0;
        if (row_top) begin
            row_code = BITS_KW'({row_x, 1'b1});
        end else if (row_bottom) begin
            row_code = BITS_KW'({row_rem, 1'b0});
        end
    end

    // A 1-wide kernel completes every member each column; inside the left
    // padding nothing is complete yet.
    always_comb begin
        mask_next = '0;
        if (kw2 == '0) begin
            mask_next = '1;
        end else if (!col_left) begin
            mask_next = period_tab[kw2] | (at_col_end ? tail_tab[kw2] : '0);
        end
    end

    // Output stage, configuration registers and position counters all move on
    // the same accepted beat, so the output reflects the pre-increment position.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            kw2         <= '0;
            kh2         <= '0;
            cols_1      <= '1;
            rows_1      <= '1;
            col         <= '0;
            row         <= '0;
            m_valid     <= 1'b0;
            m_mask_full <= '0;
            m_clr       <= '0;
            m_rcode     <= '0;
            m_config    <= 1'b0;
            m_last      <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (aclken) begin
            if (fire) begin
                m_valid  <= 1'b1;
                m_config <= s_config;
                if (s_config) begin
                    kw2         <= s_kw2;
                    kh2         <= s_kh2;
                    cols_1      <= s_cols_1;
                    rows_1      <= s_rows_1;
                    col         <= '0;
                    row         <= '0;
                    cfg_err     <= cfg_bad;
                    m_mask_full <= '1;
                    m_clr       <= '0;
                    m_rcode     <= '0;
                    m_last      <= 1'b0;
                end else begin
                    m_mask_full <= mask_next;
                    m_clr       <= col_code;
                    m_rcode     <= row_code;
                    m_last      <= s_cin_last && at_col_end && at_row_end;
                    if (s_cin_last) begin
                        if (at_col_end) begin
                            col <= '0;
                            row <= at_row_end ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pad_mask_gen.sv
// tb_pad_mask_gen
//
// Scoreboard bench for pad_mask_gen: every accepted input beat pushes the
// expected output beat, computed from an arithmetic model of the image
// position, and every output handshake pops and compares it. Output hold is
// checked on each stalled or clock-disabled cycle.
module tb_pad_mask_gen;

    localparam int MEMBERS = 24;
    localparam int HW      = 1 + MEMBERS + 3 + 3 + 1 + 1 + 1;

    typedef struct {
        logic [MEMBERS-1:0] mask;
        logic [2:0]         clr;
        logic [2:0]         rcode;
        logic               cfg;
        logic               last;
        int                 col;
        int                 cols;
        int                 kw2;
    } exp_t;

    logic               aclk;
    logic               aresetn;
    logic               aclken;
    logic               s_valid;
    logic               s_ready;
    logic               s_config;
    logic               s_cin_last;
    logic [1:0]         s_kw2;
    logic [1:0]         s_kh2;
    logic [9:0]         s_cols_1;
    logic [9:0]         s_rows_1;
    logic               m_valid;
    logic               m_ready;
    logic [MEMBERS-1:0] m_mask_full;
    logic [2:0]         m_clr;
    logic [2:0]         m_rcode;
    logic               m_config;
    logic               m_last;
    logic               cfg_err;

    exp_t               sb [$];
    int                 errCount   = 0;
    int                 checkCount = 0;
    int                 mkw2, mkh2, mcols, mrows, mcol, mrow;
    bit                 stallMode  = 0;
    bit                 enMode     = 0;
    bit                 holdPending = 0;
    logic [HW-1:0]      heldVec;
    int                 clrTbl [8] = '{1, 3, 0, 0, 0, 0, 4, 2};

    pad_mask_gen dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .aclken      (aclken),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_config    (s_config),
        .s_cin_last  (s_cin_last),
        .s_kw2       (s_kw2),
        .s_kh2       (s_kh2),
        .s_cols_1    (s_cols_1),
        .s_rows_1    (s_rows_1),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_mask_full (m_mask_full),
        .m_clr       (m_clr),
        .m_rcode     (m_rcode),
        .m_config    (m_config),
        .m_last      (m_last),
        .cfg_err     (cfg_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int edgeCode(input int p, input int h, input int last);
        if (p < h) return 2 * p + 1;
        if (p > last - h) return 2 * (last - p + 1);
        return 0;
    endfunction

    function automatic logic [MEMBERS-1:0] modelMask(input int c);
        logic [MEMBERS-1:0] v;
        int kw;
        kw = 2 * mkw2 + 1;
        for (int m = 0; m < MEMBERS; m++) begin
            if (mkw2 == 0) v[m] = 1'b1;
            else if (c < mkw2) v[m] = 1'b0;
            else v[m] = ((m % kw) == kw - 1) ||
                        (c == mcols && (m % kw) >= mkw2 && m < (MEMBERS / kw) * kw);
        end
        return v;
    endfunction

    task automatic modelPush();
        exp_t e;
        if (s_config) begin
            e.mask = '1; e.clr = 0; e.rcode = 0; e.cfg = 1; e.last = 0;
            e.col = -1; e.cols = -1; e.kw2 = -1;
            mkw2 = int'(s_kw2); mkh2 = int'(s_kh2);
            mcols = int'(s_cols_1); mrows = int'(s_rows_1);
            mcol = 0; mrow = 0;
        end else begin
            e.mask  = modelMask(mcol);
            e.clr   = 3'(edgeCode(mcol, mkw2, mcols));
            e.rcode = 3'(edgeCode(mrow, mkh2, mrows));
            e.cfg   = 0;
            e.last  = s_cin_last && mcol == mcols && mrow == mrows;
            e.col = mcol; e.cols = mcols; e.kw2 = mkw2;
            if (s_cin_last) begin
                if (mcol == mcols) begin
                    mcol = 0;
                    mrow = (mrow == mrows) ? 0 : mrow + 1;
                end else begin
                    mcol++;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic popCompare();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("unexpected_beat", 1, 0);
            return;
        end
        e = sb.pop_front();
        checkOutput("mask", m_mask_full, e.mask);
        checkOutput("clr", m_clr, e.clr);
        checkOutput("rcode", m_rcode, e.rcode);
        checkOutput("config", m_config, e.cfg);
        checkOutput("last", m_last, e.last);
        if (e.kw2 == 2 && e.cols == 7) begin
            checkOutput("clr_table", m_clr, clrTbl[e.col]);
            if (e.col == 7) checkOutput("mask_col7", m_mask_full, 24'h0E739C);
            if (e.col == 3) checkOutput("mask_col3", m_mask_full, 24'h084210);
        end
    endtask

    // One clock cycle starting at a negedge: randomise the handshake, check
    // output hold, service the scoreboard and wait for the next negedge.
    task automatic cycleStep(output bit fired);
        logic [HW-1:0] now;
        m_ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
        aclken  = (enMode && $urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
        #1;
        now = {m_valid, m_mask_full, m_clr, m_rcode, m_config, m_last, cfg_err};
        if (holdPending) checkOutput("hold", now, heldVec);
        holdPending = (m_valid && !m_ready) || !aclken;
        heldVec = now;
        if (m_valid && m_ready && aclken) popCompare();
        fired = s_valid && s_ready && aclken;
        if (fired) modelPush();
        @(negedge aclk);
    endtask

    task automatic applyStimulus(input bit cfg, input bit cinLast, input int kw2,
                                 input int kh2, input int cols, input int rows);
        bit fired;
        fired = 0;
        s_valid = 1'b1; s_config = cfg; s_cin_last = cinLast;
        s_kw2 = 2'(kw2); s_kh2 = 2'(kh2); s_cols_1 = 10'(cols); s_rows_1 = 10'(rows);
        for (int n = 0; n < 100 && !fired; n++) cycleStep(fired);
        if (!fired) checkOutput("xfer_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit fired;
        s_valid = 1'b0;
        for (int n = 0; n < 400 && (sb.size() > 0 || m_valid); n++) cycleStep(fired);
        if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    task automatic runFrame(input int kw2, input int kh2, input int cols,
                            input int rows, input int nonLast);
        applyStimulus(1, 0, kw2, kh2, cols, rows);
        for (int p = 0; p < (cols + 1) * (rows + 1); p++) begin
            for (int k = 0; k < nonLast; k++) applyStimulus(0, 0, kw2, kh2, cols, rows);
            applyStimulus(0, 1, kw2, kh2, cols, rows);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, m_valid, 0);
        checkOutput({tag, "_mask"}, m_mask_full, 0);
        checkOutput({tag, "_codes"}, {m_clr, m_rcode}, 0);
        checkOutput({tag, "_flags"}, {m_config, m_last, cfg_err}, 0);
    endtask

    initial begin
        aresetn = 1'b0; aclken = 1'b1; m_ready = 1'b1;
        s_valid = 1'b0; s_config = 1'b0; s_cin_last = 1'b0;
        s_kw2 = '0; s_kh2 = '0; s_cols_1 = '0; s_rows_1 = '0;
        mkw2 = 0; mkh2 = 0; mcols = 1023; mrows = 1023; mcol = 0; mrow = 0;
        repeat (3) @(negedge aclk);
        checkResetOutputs("reset");
        checkOutput("reset_s_ready", s_ready, 1);
        aresetn = 1'b1;
        @(negedge aclk);

        $display("[TB] frame kw=5 kh=3 8x4, no stalls");
        runFrame(2, 1, 7, 3, 0);
        drain();
        checkOutput("cfg_err_legal", cfg_err, 0);

        $display("[TB] two frames with random stalls and clock-enable gaps");
        stallMode = 1; enMode = 1;
        runFrame(2, 1, 7, 3, 0);
        runFrame(3, 3, 9, 6, 0);
        drain();

        $display("[TB] interleaved non-last channel beats");
        runFrame(2, 1, 7, 3, 3);
        drain();
        stallMode = 0; enMode = 0;

        $display("[TB] 1-wide kernel and mid-frame reconfiguration");
        runFrame(0, 0, 3, 1, 0);
        applyStimulus(1, 0, 1, 1, 4, 2);
        for (int p = 0; p < 6; p++) applyStimulus(0, 1, 1, 1, 4, 2);
        runFrame(1, 2, 4, 5, 0);
        drain();

        $display("[TB] illegal configuration");
        applyStimulus(1, 0, 2, 0, 2, 0);
        drain();
        checkOutput("cfg_err_set", cfg_err, 1);
        applyStimulus(1, 0, 1, 0, 2, 0);
        drain();
        checkOutput("cfg_err_clear", cfg_err, 0);

        $display("[TB] asynchronous reset mid-row 2");
        applyStimulus(1, 0, 2, 1, 7, 3);
        for (int p = 0; p < 19; p++) applyStimulus(0, 1, 2, 1, 7, 3);
        #3;
        aresetn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        holdPending = 0;
        mkw2 = 0; mkh2 = 0; mcols = 1023; mrows = 1023; mcol = 0; mrow = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        runFrame(2, 1, 7, 3, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
